// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter and the LSU/DCache side:
// FSM state encoding, access width codes, default refill length and the memory command payload.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned BEAT_W             = 3;
    localparam int unsigned DEFAULT_LINE_WORDS = 4;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_FILL = 2'd1,
        ST_D_ACC  = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    typedef struct packed {
        logic              we;
        logic [1:0]        width;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Start address of the refill line containing addr.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr,
                                                    input int unsigned       line_words);
        return addr & ~(ADDR_W'(line_words * 4) - ADDR_W'(1));
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin tie-break between instruction and data requesters.
// On a tie the requester that was not granted last wins; the last grant updates only when a grant is taken.
module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic req_d,
    input  logic take,
    output logic grant_i_c,
    output logic grant_d_c
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    always_comb begin
        grant_i_c    = req_i && (!req_d || (last_grant_q == GRANT_D));
        grant_d_c    = req_d && (!req_i || (last_grant_q == GRANT_I));
        last_grant_d = last_grant_q;
        if (take) begin
            last_grant_d = grant_d_c ? GRANT_D : GRANT_I;
        end
    end

    // Reset to D so the instruction side wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_q <= GRANT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction-line refills (LINE_WORDS-beat bursts)
// and single data accesses; every output is registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [BEAT_W-1:0] i_beat,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_width,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_width,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    arb_state_e        state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              mem_req_q, mem_req_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic [BEAT_W-1:0] i_beat_q, i_beat_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_i_c, grant_d_c;
    logic arb_take_c, fire_c, last_beat_c;

    // Acks only count while a transfer is actually requested.
    assign arb_take_c  = (state_q == ST_IDLE) && (i_req || d_req);
    assign fire_c      = mem_req_q && mem_ack;
    assign last_beat_c = (beat_q == LAST_BEAT);

    mem_arb_rr u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    (i_req),
        .req_d    (d_req),
        .take     (arb_take_c),
        .grant_i_c(grant_i_c),
        .grant_d_c(grant_d_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_i_c) begin
                    state_d = ST_I_FILL;
                end else if (grant_d_c) begin
                    state_d = ST_D_ACC;
                end
            end
            ST_I_FILL: if (fire_c && last_beat_c) state_d = ST_RESP;
            ST_D_ACC:  if (fire_c) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_d  = mem_req_q;
        cmd_d      = cmd_q;
        beat_d     = beat_q;
        i_rvalid_d = 1'b0;
        i_beat_d   = i_beat_q;
        i_rdata_d  = i_rdata_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_i_c) begin
                    mem_req_d = 1'b1;
                    cmd_d     = '{we: 1'b0, width: WIDTH_WORD,
                                  addr: line_base(i_addr, LINE_WORDS), wdata: '0};
                    beat_d    = '0;
                end else if (grant_d_c) begin
                    mem_req_d = 1'b1;
                    cmd_d     = '{we: d_we, width: d_width, addr: d_addr, wdata: d_wdata};
                end
            end
            ST_I_FILL: begin
                if (fire_c) begin
                    i_rvalid_d = 1'b1;
                    i_beat_d   = beat_q;
                    i_rdata_d  = mem_rdata;
                    beat_d     = beat_q + BEAT_W'(1);
                    cmd_d.addr = cmd_q.addr + ADDR_W'(4);
                    if (last_beat_c) begin
                        mem_req_d = 1'b0;
                        i_ack_d   = 1'b1;
                    end
                end
            end
            ST_D_ACC: begin
                if (fire_c) begin
                    mem_req_d = 1'b0;
                    cmd_d.we  = 1'b0;
                    d_ack_d   = 1'b1;
                    d_rdata_d = cmd_q.we ? '0 : mem_rdata;
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_q      <= '0;
            beat_q     <= '0;
            mem_req_q  <= 1'b0;
            i_rvalid_q <= 1'b0;
            i_beat_q   <= '0;
            i_rdata_q  <= '0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            cmd_q      <= cmd_d;
            beat_q     <= beat_d;
            mem_req_q  <= mem_req_d;
            i_rvalid_q <= i_rvalid_d;
            i_beat_q   <= i_beat_d;
            i_rdata_q  <= i_rdata_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_width = cmd_q.width;
    assign i_rvalid  = i_rvalid_q;
    assign i_beat    = i_beat_q;
    assign i_rdata   = i_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector tables for load/refill/store/tie traffic,
// plus hand sequences for reset values, stuck mem_ack and reset in the middle of a refill.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [1:0]  d_width;
    logic        i_rvalid, i_ack, d_ack, mem_req, mem_we;
    logic [2:0]  i_beat;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_width;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        i_req;    logic [31:0] i_addr;
        logic        d_req;    logic        d_we;
        logic [31:0] d_addr;   logic [31:0] d_wdata;  logic [1:0] d_width;
        logic        ack;      logic [31:0] rdata;
        logic        e_req;    logic [31:0] e_addr;   logic       e_we;
        logic [1:0]  e_width;  logic [31:0] e_wdata;
        logic        e_rvalid; logic [2:0]  e_beat;   logic [31:0] e_irdata;
        logic        e_iack;   logic        e_dack;   logic [31:0] e_drdata;
    } vec_t;

    vec_t vecs[$];

    mem_arbiter #(.LINE_WORDS(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_beat(i_beat),
        .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_width(mem_width), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic i_req_v, input logic [31:0] i_addr_v,
        input logic d_req_v, input logic d_we_v, input logic [31:0] d_addr_v,
        input logic [31:0] d_wdata_v, input logic [1:0] d_width_v,
        input logic ack_v, input logic [31:0] rdata_v,
        input logic e_req, input logic [31:0] e_addr, input logic e_we,
        input logic [1:0] e_width, input logic [31:0] e_wdata,
        input logic e_rvalid, input logic [2:0] e_beat, input logic [31:0] e_irdata,
        input logic e_iack, input logic e_dack, input logic [31:0] e_drdata);
        vec_t t;
        t.i_req = i_req_v; t.i_addr = i_addr_v;
        t.d_req = d_req_v; t.d_we = d_we_v; t.d_addr = d_addr_v;
        t.d_wdata = d_wdata_v; t.d_width = d_width_v;
        t.ack = ack_v; t.rdata = rdata_v;
        t.e_req = e_req; t.e_addr = e_addr; t.e_we = e_we; t.e_width = e_width;
        t.e_wdata = e_wdata; t.e_rvalid = e_rvalid; t.e_beat = e_beat;
        t.e_irdata = e_irdata; t.e_iack = e_iack; t.e_dack = e_dack; t.e_drdata = e_drdata;
        return t;
    endfunction

    task automatic clear_inputs();
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_width = 2'd0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // Ends just after a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic apply_vec(input string tag, input int k, input vec_t t);
        string p;
        p = $sformatf("%s[%0d]", tag, k);
        @(negedge clk);
        i_req = t.i_req; i_addr = t.i_addr; d_req = t.d_req; d_we = t.d_we;
        d_addr = t.d_addr; d_wdata = t.d_wdata; d_width = t.d_width;
        mem_ack = t.ack; mem_rdata = t.rdata;
        @(posedge clk);
        #1;
        chk({p, " mem_req"},  32'(mem_req),  32'(t.e_req));
        chk({p, " i_rvalid"}, 32'(i_rvalid), 32'(t.e_rvalid));
        chk({p, " i_ack"},    32'(i_ack),    32'(t.e_iack));
        chk({p, " d_ack"},    32'(d_ack),    32'(t.e_dack));
        if (t.e_req) begin
            chk({p, " mem_addr"},  mem_addr,         t.e_addr);
            chk({p, " mem_we"},    32'(mem_we),      32'(t.e_we));
            chk({p, " mem_width"}, 32'(mem_width),   32'(t.e_width));
            if (t.e_we) chk({p, " mem_wdata"}, mem_wdata, t.e_wdata);
        end
        if (t.e_rvalid) begin
            chk({p, " i_beat"},  32'(i_beat), 32'(t.e_beat));
            chk({p, " i_rdata"}, i_rdata,     t.e_irdata);
        end
        if (t.e_dack) chk({p, " d_rdata"}, d_rdata, t.e_drdata);
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[k]) apply_vec(tag, k, vecs[k]);
        vecs.delete();
    endtask

    initial begin
        bit got;
        int iack_seen;
        clear_inputs();

        // Reset values
        do_reset();
        chk("rst mem_req",   32'(mem_req),   32'd0);
        chk("rst mem_we",    32'(mem_we),    32'd0);
        chk("rst mem_addr",  mem_addr,       32'd0);
        chk("rst mem_wdata", mem_wdata,      32'd0);
        chk("rst i_rvalid",  32'(i_rvalid),  32'd0);
        chk("rst i_beat",    32'(i_beat),    32'd0);
        chk("rst i_rdata",   i_rdata,        32'd0);
        chk("rst i_ack",     32'(i_ack),     32'd0);
        chk("rst d_ack",     32'(d_ack),     32'd0);
        chk("rst d_rdata",   d_rdata,        32'd0);

        // Load with mem_ack two cycles after mem_req rises: mem_req high exactly 3 cycles
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h0,          1'b1, 32'h100, 1'b0, 2'd2, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h0,          1'b1, 32'h100, 1'b0, 2'd2, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h0,          1'b1, 32'h100, 1'b0, 2'd2, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b1, 32'hDEADBEEF,   1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h0,          1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,            1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        // Refill from 0x1234, mem_ack every cycle
        vecs.push_back(mk(1'b1, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,         1'b1, 32'h1230, 1'b0, 2'd2, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hA0,        1'b1, 32'h1234, 1'b0, 2'd2, 32'h0, 1'b1, 3'd0, 32'hA0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hA1,        1'b1, 32'h1238, 1'b0, 2'd2, 32'h0, 1'b1, 3'd1, 32'hA1, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hA2,        1'b1, 32'h123C, 1'b0, 2'd2, 32'h0, 1'b1, 3'd2, 32'hA2, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'hA3,        1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b1, 3'd3, 32'hA3, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,            1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        // Byte store: stores return zero data
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h203, 32'hAB, 2'd0, 1'b0, 32'h0,         1'b1, 32'h203, 1'b1, 2'd0, 32'hAB, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h203, 32'hAB, 2'd0, 1'b1, 32'h55,        1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h203, 32'hAB, 2'd0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,            1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        // Width code 3 passes through unchanged
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h208, 32'h0, 2'd3, 1'b0, 32'h0,          1'b1, 32'h208, 1'b0, 2'd3, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h208, 32'h0, 2'd3, 1'b1, 32'h11223344,   1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h11223344));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h208, 32'h0, 2'd3, 1'b0, 32'h0,          1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        run_table("basic");

        // Ties after reset: I first, waiting D next, then alternation
        do_reset();
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b1, 32'h500, 32'hCAFE, 2'd2, 1'b0, 32'h0,      1'b1, 32'h40, 1'b0, 2'd2, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b1, 32'h500, 32'hCAFE, 2'd2, 1'b1, 32'h10,     1'b1, 32'h44, 1'b0, 2'd2, 32'h0, 1'b1, 3'd0, 32'h10, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b1, 32'h500, 32'hCAFE, 2'd2, 1'b1, 32'h11,     1'b1, 32'h48, 1'b0, 2'd2, 32'h0, 1'b1, 3'd1, 32'h11, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b1, 32'h500, 32'hCAFE, 2'd2, 1'b1, 32'h12,     1'b1, 32'h4C, 1'b0, 2'd2, 32'h0, 1'b1, 3'd2, 32'h12, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b1, 32'h500, 32'hCAFE, 2'd2, 1'b1, 32'h13,     1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b1, 3'd3, 32'h13, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b1, 32'h500, 32'hCAFE, 2'd2, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h4C, 1'b1, 1'b1, 32'h500, 32'hCAFE, 2'd2, 1'b0, 32'h0,      1'b1, 32'h500, 1'b1, 2'd2, 32'hCAFE, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b1, 32'h500, 32'hCAFE, 2'd2, 1'b1, 32'h99,     1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b1, 32'h500, 32'hCAFE, 2'd2, 1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b0, 32'h0,         1'b1, 32'h40, 1'b0, 2'd2, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b1, 32'h20,        1'b1, 32'h44, 1'b0, 2'd2, 32'h0, 1'b1, 3'd0, 32'h20, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b1, 32'h21,        1'b1, 32'h48, 1'b0, 2'd2, 32'h0, 1'b1, 3'd1, 32'h21, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b1, 32'h22,        1'b1, 32'h4C, 1'b0, 2'd2, 32'h0, 1'b1, 3'd2, 32'h22, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b1, 32'h23,        1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b1, 3'd3, 32'h23, 1'b1, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b0, 32'h0,         1'b1, 32'h600, 1'b0, 2'd2, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b1, 32'h77,        1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 32'h77));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 2'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 32'h4C, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0,           1'b1, 32'h40, 1'b0, 2'd2, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0));
        run_table("tie");

        // Stuck-high mem_ack while idle
        do_reset();
        mem_ack = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stuck[%0d] {mem_req,i_rvalid,i_ack,d_ack}", c),
                32'({mem_req, i_rvalid, i_ack, d_ack}), 32'd0);
        end
        @(negedge clk);
        mem_ack = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_width = 2'd2;
        @(posedge clk);
        #1;
        chk("stuck grant mem_req", 32'(mem_req), 32'd1);
        chk("stuck grant mem_addr", mem_addr, 32'h700);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(posedge clk);
        #1;
        chk("stuck d_ack", 32'(d_ack), 32'd1);
        chk("stuck d_rdata", d_rdata, 32'h0BADF00D);

        // Reset after beat 1 of a refill abandons it
        do_reset();
        i_req = 1'b1; i_addr = 32'h84;
        @(posedge clk);
        #1;
        chk("midrst mem_req", 32'(mem_req), 32'd1);
        chk("midrst mem_addr", mem_addr, 32'h80);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1;
        @(posedge clk);
        #1;
        chk("midrst beat0", 32'(i_beat), 32'd0);
        @(negedge clk);
        mem_rdata = 32'h2;
        @(posedge clk);
        #1;
        chk("midrst beat1", 32'(i_beat), 32'd1);
        @(negedge clk);
        reset = 1'b0; i_req = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst mem_req after reset", 32'(mem_req), 32'd0);
        chk("midrst i_ack after reset", 32'(i_ack), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        iack_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("midrst stray[%0d] {mem_req,i_rvalid,i_ack,d_ack}", c),
                32'({mem_req, i_rvalid, i_ack, d_ack}), 32'd0);
        end
        @(negedge clk);
        mem_ack = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_width = 2'd2;
        mem_rdata = 32'h12345678;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            mem_ack = mem_req;
            @(posedge clk);
            #1;
            if (i_ack) iack_seen++;
            if (d_ack) begin
                got = 1'b1;
                chk("midrst load d_rdata", d_rdata, 32'h12345678);
            end else if (mem_req) begin
                chk("midrst load mem_addr", mem_addr, 32'h300);
            end
        end
        chk("midrst load d_ack seen", 32'(got), 32'd1);
        chk("midrst no i_ack", 32'(iack_seen), 32'd0);
        @(negedge clk);
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
